estagio_busca: RTL and testbench

//  IF stage of the 5-stage RV32I pipeline, directly upstream of ID (register file + decode).

---
 rtl/estagio_busca_if.sv | 16 +
 rtl/estagio_busca.sv | 202 ++++++++++++++++++++
 tb/tb_estagio_busca.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/estagio_busca_if.sv
// Instruction-memory port of the IF stage.
// The fetch stage is the master: it raises mem_req with a stable mem_endereco
// until the memory answers with a one-cycle mem_ack carrying mem_dado.
//  mem_req      master -> slave  fetch request
//  mem_endereco master -> slave  fetch address (word aligned)
//  mem_ack      slave -> master  data valid / request retired (1-cycle pulse)
//  mem_dado     slave -> master  fetched instruction
interface estagio_busca_if;
  logic        mem_req;
  logic [31:0] mem_endereco;
  logic        mem_ack;
  logic [31:0] mem_dado;

  modport master (output mem_req, output mem_endereco, input mem_ack, input mem_dado);
  modport slave  (input mem_req, input mem_endereco, output mem_ack, output mem_dado);
endinterface

// File: rtl/estagio_busca.sv
// IF stage of the 5-stage RV32I pipeline.
// Owns the PC, issues one outstanding fetch at a time on the instruction-memory
// port and loads the IF/ID pipeline register. Honours the hazard-unit stall and
// the EX redirect; a redirect that arrives while a fetch is still outstanding
// waits for that fetch to retire and discards its data.
// Ports:
//  clk, reset          clock, asynchronous active-high reset
//  stall               hold IF/ID, do not advance
//  desvio_tomado       redirect fetch to endereco_desvio and flush IF/ID
//  endereco_desvio     redirect target (bits [1:0] ignored)
//  mem                 instruction-memory port (master side)
//  if_id_pc            PC of the instruction held in IF/ID
//  if_id_pc_mais4      if_id_pc + 4
//  if_id_instrucao     instruction held in IF/ID
//  if_id_valido        IF/ID holds a real instruction
module estagio_busca #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] INSTR_NOP = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   desvio_tomado,
  input  logic [31:0]            endereco_desvio,
  estagio_busca_if.master        mem,
  output logic [31:0]            if_id_pc,
  output logic [31:0]            if_id_pc_mais4,
  output logic [31:0]            if_id_instrucao,
  output logic                   if_id_valido
);

  // INICIO: idle cycle after reset; BUSCA: fetch at pc outstanding;
  // RETIDO: fetched word parked while ID stalls; DESCARTA: outstanding fetch
  // belongs to the wrong path and its data will be dropped.
  typedef enum logic [1:0] {
    INICIO   = 2'd0,
    BUSCA    = 2'd1,
    RETIDO   = 2'd2,
    DESCARTA = 2'd3
  } estado_t;

  estado_t     estado_r, estado_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] pc_pendente_r, pc_pendente_s;
  logic [31:0] buf_instr_r, buf_instr_s;
  logic [31:0] buf_pc_r, buf_pc_s;
  logic        mem_req_r, mem_req_s;
  logic [31:0] ifid_pc_r, ifid_pc_s;
  logic [31:0] ifid_pc4_r, ifid_pc4_s;
  logic [31:0] ifid_instr_r, ifid_instr_s;
  logic        ifid_valido_r, ifid_valido_s;

  logic [31:0] alvo_s;
  logic [31:0] pc_mais4_s;
  logic        bolha_s;
  logic        carrega_s;
  logic [31:0] nova_pc_s;
  logic [31:0] nova_instr_s;

  // Redirect targets are forced to word alignment; pc+4 wraps naturally mod 2^32.
  assign alvo_s     = {endereco_desvio[31:2], 2'b00};
  assign pc_mais4_s = pc_r + 32'd4;

  // Next-state, next-PC and IF/ID load selection.
  always_comb begin
    estado_s      = estado_r;
    pc_s          = pc_r;
    pc_pendente_s = pc_pendente_r;
    buf_instr_s   = buf_instr_r;
    buf_pc_s      = buf_pc_r;
    bolha_s       = 1'b0;
    carrega_s     = 1'b0;
    nova_pc_s     = pc_r;
    nova_instr_s  = mem.mem_dado;

    case (estado_r)
      INICIO: begin
        estado_s = BUSCA;
        bolha_s  = desvio_tomado || !stall;
      end

      BUSCA: begin
        if (desvio_tomado) begin
          bolha_s = 1'b1;
          if (mem.mem_ack) begin
            pc_s = alvo_s;
          end else begin
            // Fetch in flight on the old path: remember the target, drop it later.
            pc_pendente_s = alvo_s;
            estado_s      = DESCARTA;
          end
        end else if (mem.mem_ack) begin
          if (stall) begin
            buf_instr_s = mem.mem_dado;
            buf_pc_s    = pc_r;
            estado_s    = RETIDO;
          end else begin
            carrega_s    = 1'b1;
            nova_pc_s    = pc_r;
            nova_instr_s = mem.mem_dado;
            pc_s         = pc_mais4_s;
          end
        end else begin
          bolha_s = !stall;
        end
      end

      RETIDO: begin
        if (desvio_tomado) begin
          pc_s     = alvo_s;
          bolha_s  = 1'b1;
          estado_s = BUSCA;
        end else if (!stall) begin
          carrega_s    = 1'b1;
          nova_pc_s    = buf_pc_r;
          nova_instr_s = buf_instr_r;
          pc_s         = buf_pc_r + 32'd4;
          estado_s     = BUSCA;
        end else begin
          estado_s = RETIDO;
        end
      end

      DESCARTA: begin
        bolha_s = desvio_tomado || !stall;
        if (mem.mem_ack) begin
          // A redirect in the same cycle as the retiring ack is the newest one.
          pc_s     = desvio_tomado ? alvo_s : pc_pendente_r;
          estado_s = BUSCA;
        end else if (desvio_tomado) begin
          pc_pendente_s = alvo_s;
        end else begin
          estado_s = DESCARTA;
        end
      end

      default: begin
        estado_s = INICIO;
        bolha_s  = 1'b1;
      end
    endcase
  end

  // IF/ID next value: bubble beats new data; neither means hold.
  always_comb begin
    ifid_pc_s     = ifid_pc_r;
    ifid_pc4_s    = ifid_pc4_r;
    ifid_instr_s  = ifid_instr_r;
    ifid_valido_s = ifid_valido_r;
    if (bolha_s) begin
      ifid_pc_s     = pc_r;
      ifid_pc4_s    = pc_mais4_s;
      ifid_instr_s  = INSTR_NOP;
      ifid_valido_s = 1'b0;
    end else if (carrega_s) begin
      ifid_pc_s     = nova_pc_s;
      ifid_pc4_s    = nova_pc_s + 32'd4;
      ifid_instr_s  = nova_instr_s;
      ifid_valido_s = 1'b1;
    end else begin
      ifid_valido_s = ifid_valido_r;
    end
  end

  // Request is registered alongside the state it is decoded from.
  assign mem_req_s = (estado_s == BUSCA) || (estado_s == DESCARTA);

  // State, PC, parking buffer and IF/ID registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_r      <= INICIO;
      pc_r          <= PC_RESET;
      pc_pendente_r <= PC_RESET;
      buf_instr_r   <= INSTR_NOP;
      buf_pc_r      <= PC_RESET;
      mem_req_r     <= 1'b0;
      ifid_pc_r     <= PC_RESET;
      ifid_pc4_r    <= PC_RESET + 32'd4;
      ifid_instr_r  <= INSTR_NOP;
      ifid_valido_r <= 1'b0;
    end else begin
      estado_r      <= estado_s;
      pc_r          <= pc_s;
      pc_pendente_r <= pc_pendente_s;
      buf_instr_r   <= buf_instr_s;
      buf_pc_r      <= buf_pc_s;
      mem_req_r     <= mem_req_s;
      ifid_pc_r     <= ifid_pc_s;
      ifid_pc4_r    <= ifid_pc4_s;
      ifid_instr_r  <= ifid_instr_s;
      ifid_valido_r <= ifid_valido_s;
    end
  end

  assign mem.mem_req      = mem_req_r;
  assign mem.mem_endereco = pc_r;
  assign if_id_pc         = ifid_pc_r;
  assign if_id_pc_mais4   = ifid_pc4_r;
  assign if_id_instrucao  = ifid_instr_r;
  assign if_id_valido     = ifid_valido_r;

endmodule

// File: tb/tb_estagio_busca.sv
// Self-checking bench for estagio_busca: directed scenarios with literal
// expectations, then randomized stall/redirect/ack traffic checked every cycle
// against a behavioural model of the fetch stage.
module tb_estagio_busca;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        desvio_tomado;
  logic [31:0] endereco_desvio;
  logic [31:0] if_id_pc, if_id_pc_mais4, if_id_instrucao;
  logic        if_id_valido;

  estagio_busca_if mem_bus ();

  estagio_busca dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .desvio_tomado   (desvio_tomado),
    .endereco_desvio (endereco_desvio),
    .mem             (mem_bus),
    .if_id_pc        (if_id_pc),
    .if_id_pc_mais4  (if_id_pc_mais4),
    .if_id_instrucao (if_id_instrucao),
    .if_id_valido    (if_id_valido)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_vec++;
    if (atual !== esperado) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nome, atual, esperado, $time);
    end
  endtask

  // Behavioural model: where the next fetch goes, whether the outstanding
  // fetch is on a dead path, and at most one parked word waiting for ID.
  logic        m_boot;       // idle cycle after reset
  logic [31:0] m_pc;         // address of the current / next fetch
  logic        m_drop;       // outstanding fetch must be thrown away
  logic [31:0] m_redir;      // where to go once the dropped fetch retires
  logic        m_hv;         // a fetched word is parked
  logic [31:0] m_hpc, m_hinstr;
  logic [31:0] m_ipc, m_iinstr;
  logic        m_iv;

  always @(posedge clk or posedge reset) begin
    logic b, d, hv, iv, ack;
    logic [31:0] p, po, r, hp, hi, ip, ii, tgt;
    if (reset) begin
      m_boot <= 1'b1; m_pc <= 32'h0; m_drop <= 1'b0; m_redir <= 32'h0;
      m_hv <= 1'b0; m_hpc <= 32'h0; m_hinstr <= 32'h0;
      m_ipc <= 32'h0; m_iinstr <= NOP; m_iv <= 1'b0;
    end else begin
      b = m_boot; d = m_drop; hv = m_hv; r = m_redir; hp = m_hpc; hi = m_hinstr;
      ip = m_ipc; ii = m_iinstr; iv = m_iv;
      po = m_pc; p = m_pc;
      tgt = endereco_desvio & 32'hFFFF_FFFC;
      ack = mem_bus.mem_ack;
      if (b) begin
        b = 1'b0;
        if (desvio_tomado || !stall) begin ip = po; ii = NOP; iv = 1'b0; end
      end else if (hv) begin
        if (desvio_tomado) begin
          hv = 1'b0; p = tgt; ip = po; ii = NOP; iv = 1'b0;
        end else if (!stall) begin
          hv = 1'b0; ip = hp; ii = hi; iv = 1'b1; p = hp + 32'd4;
        end
      end else if (d) begin
        if (desvio_tomado || !stall) begin ip = po; ii = NOP; iv = 1'b0; end
        if (ack) begin
          p = desvio_tomado ? tgt : r; d = 1'b0;
        end else if (desvio_tomado) begin
          r = tgt;
        end
      end else begin
        if (desvio_tomado) begin
          ip = po; ii = NOP; iv = 1'b0;
          if (ack) p = tgt;
          else begin d = 1'b1; r = tgt; end
        end else if (ack) begin
          if (stall) begin hv = 1'b1; hp = po; hi = mem_bus.mem_dado; end
          else begin ip = po; ii = mem_bus.mem_dado; iv = 1'b1; p = po + 32'd4; end
        end else if (!stall) begin
          ip = po; ii = NOP; iv = 1'b0;
        end
      end
      m_boot <= b; m_pc <= p; m_drop <= d; m_redir <= r;
      m_hv <= hv; m_hpc <= hp; m_hinstr <= hi;
      m_ipc <= ip; m_iinstr <= ii; m_iv <= iv;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    logic exp_req;
    exp_req = !m_boot && !m_hv;
    chk("mem_req", {31'd0, mem_bus.mem_req}, {31'd0, exp_req});
    if (exp_req) chk("mem_endereco", mem_bus.mem_endereco, m_pc);
    chk("if_id_pc", if_id_pc, m_ipc);
    chk("if_id_pc_mais4", if_id_pc_mais4, m_ipc + 32'd4);
    chk("if_id_instrucao", if_id_instrucao, m_iinstr);
    chk("if_id_valido", {31'd0, if_id_valido}, {31'd0, m_iv});
  end

  task automatic step(input logic s, input logic d, input logic [31:0] t,
                      input logic a, input logic [31:0] dd);
    stall = s; desvio_tomado = d; endereco_desvio = t;
    mem_bus.mem_ack = a; mem_bus.mem_dado = dd;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; desvio_tomado = 1'b0; endereco_desvio = 32'h0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_dado = 32'h0;
    @(negedge clk); @(negedge clk);
    chk("rst_pc", if_id_pc, 32'h0);
    chk("rst_instr", if_id_instrucao, NOP);
    chk("rst_req", {31'd0, mem_bus.mem_req}, 32'd0);
    reset = 1'b0;
    #1 chk("idle_req", {31'd0, mem_bus.mem_req}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t1_req", {31'd0, mem_bus.mem_req}, 32'd1);
    chk("t1_addr0", mem_bus.mem_endereco, 32'h0);

    // back-to-back fetches
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hAAAA_0001);
    chk("t1_pc0", if_id_pc, 32'h0);
    chk("t1_instr0", if_id_instrucao, 32'hAAAA_0001);
    chk("t1_addr4", mem_bus.mem_endereco, 32'h4);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hAAAA_0002);
    chk("t1_pc4", if_id_pc, 32'h4);
    chk("t1_addr8", mem_bus.mem_endereco, 32'h8);

    // ack under stall parks the word
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h0050_0093);
    chk("t3_req", {31'd0, mem_bus.mem_req}, 32'd0);
    chk("t3_hold", if_id_pc, 32'h4);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t3_hold_instr", if_id_instrucao, 32'hAAAA_0002);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t3_pc8", if_id_pc, 32'h8);
    chk("t3_instr", if_id_instrucao, 32'h0050_0093);
    chk("t3_addrC", mem_bus.mem_endereco, 32'hC);

    // three-cycle ack latency
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t2_addr_held", mem_bus.mem_endereco, 32'hC);
    chk("t2_bubble", {31'd0, if_id_valido}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hBBBB_000C);
    chk("t2_valid", {31'd0, if_id_valido}, 32'd1);
    chk("t2_pc", if_id_pc, 32'hC);

    // redirect while fetch at 0x10 is outstanding
    step(1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    chk("t4_addr_kept", mem_bus.mem_endereco, 32'h10);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    chk("t4_dropped", {31'd0, if_id_valido}, 32'd0);
    chk("t4_addr100", mem_bus.mem_endereco, 32'h100);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hCCCC_0100);
    chk("t4_pc100", if_id_pc, 32'h100);

    // redirect with stall, misaligned target
    step(1'b1, 1'b1, 32'h0000_0203, 1'b1, 32'h1111_1111);
    chk("t5_nop", if_id_instrucao, NOP);
    chk("t5_addr200", mem_bus.mem_endereco, 32'h200);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h2222_2222);
    chk("t5_pc200", if_id_pc, 32'h200);

    // PC wrap
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h3333_3333);
    chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_id_pc_mais4, 32'h0);
    chk("wrap_addr", mem_bus.mem_endereco, 32'h0);

    // async reset while a dropped fetch is outstanding
    step(1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
    reset = 1'b1;
    #1;
    chk("t6_req", {31'd0, mem_bus.mem_req}, 32'd0);
    chk("t6_valid", {31'd0, if_id_valido}, 32'd0);
    chk("t6_instr", if_id_instrucao, NOP);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("t6_idle", {31'd0, mem_bus.mem_req}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t6_addr0", mem_bus.mem_endereco, 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom,
           $urandom_range(0, 1) == 1, $urandom);
    end
    reset = 1'b0;
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
